sr_jk_ff_bank: RTL and testbench

- Parametrised bank of WIDTH edge-triggered storage cells with a runtime-selectable mode: SR, JK, D or T.
- Successor to the single-bit gated NAND SR latch. Adds a synchronous reset, an enable, selectable SR input polarity and per-channel sticky forbidden-input flags.
- Adds a per-channel change strobe, and serves as the general storage primitive for control and status registers in the lab designs.

---
 rtl/sr_jk_ff_bank.sv | 125 ++++++++++++
 tb/tb_sr_jk_ff_bank.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sr_jk_ff_bank.sv
// Bank of WIDTH independent edge-triggered cells with a runtime mode (SR/JK/D/T),
// sticky forbidden-SR flags and a per-channel change strobe.
module sr_jk_ff_bank #(
  parameter int WIDTH      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             illegal_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] illegal,
  output logic [WIDTH-1:0] chg
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] q_r, qn_r, illegal_r, chg_r;
  logic [WIDTH-1:0] q_nxt_s, qn_nxt_s, ill_set_s, ill_nxt_s, chg_nxt_s;
  logic [WIDTH-1:0] sa_s, ra_s;

  // SR inputs normalised to active-high regardless of polarity parameter.
  assign sa_s = ACTIVE_LOW ? ~s : s;
  assign ra_s = ACTIVE_LOW ? ~r : r;

  // Per-channel next-state and complement computation for the selected mode.
  always_comb begin
    q_nxt_s   = q_r;
    qn_nxt_s  = qn_r;
    ill_set_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      case (mode)
        MODE_SR: begin
          case ({sa_s[i], ra_s[i]})
            2'b00: begin
              q_nxt_s[i]  = q_r[i];
              qn_nxt_s[i] = ~q_r[i];
            end
            2'b10: begin
              q_nxt_s[i]  = 1'b1;
              qn_nxt_s[i] = 1'b0;
            end
            2'b01: begin
              q_nxt_s[i]  = 1'b0;
              qn_nxt_s[i] = 1'b1;
            end
            default: begin
              // Forbidden input: both outputs high, as a NAND latch would show.
              q_nxt_s[i]   = 1'b1;
              qn_nxt_s[i]  = 1'b1;
              ill_set_s[i] = 1'b1;
            end
          endcase
        end
        MODE_JK: begin
          case ({s[i], r[i]})
            2'b00:   q_nxt_s[i] = q_r[i];
            2'b10:   q_nxt_s[i] = 1'b1;
            2'b01:   q_nxt_s[i] = 1'b0;
            default: q_nxt_s[i] = ~q_r[i];
          endcase
          qn_nxt_s[i] = ~q_nxt_s[i];
        end
        MODE_D: begin
          q_nxt_s[i]  = s[i];
          qn_nxt_s[i] = ~s[i];
        end
        MODE_T: begin
          q_nxt_s[i]  = q_r[i] ^ s[i];
          qn_nxt_s[i] = ~(q_r[i] ^ s[i]);
        end
        default: begin
          q_nxt_s[i]  = q_r[i];
          qn_nxt_s[i] = qn_r[i];
        end
      endcase
    end
  end

  // Sticky flag and change-strobe next values; a new forbidden input beats the clear.
  always_comb begin
    ill_nxt_s = illegal_r;
    chg_nxt_s = {WIDTH{1'b0}};
    if (en) begin
      ill_nxt_s = (illegal_clr ? {WIDTH{1'b0}} : illegal_r) | ill_set_s;
      chg_nxt_s = q_nxt_s ^ q_r;
    end else begin
      ill_nxt_s = illegal_clr ? {WIDTH{1'b0}} : illegal_r;
      chg_nxt_s = {WIDTH{1'b0}};
    end
  end

  // State registers with synchronous reset taking priority over any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r       <= {WIDTH{1'b0}};
      qn_r      <= {WIDTH{1'b1}};
      illegal_r <= {WIDTH{1'b0}};
      chg_r     <= {WIDTH{1'b0}};
    end else begin
      if (en) begin
        q_r  <= q_nxt_s;
        qn_r <= qn_nxt_s;
      end else begin
        q_r  <= q_r;
        qn_r <= qn_r;
      end
      illegal_r <= ill_nxt_s;
      chg_r     <= chg_nxt_s;
    end
  end

  assign q       = q_r;
  assign qn      = qn_r;
  assign illegal = illegal_r;
  assign chg     = chg_r;

endmodule

// File: tb/tb_sr_jk_ff_bank.sv
// Directed vector bench for sr_jk_ff_bank: active-low instance driven from a table,
// active-high instance driven by a short hand-written sequence.
module tb_sr_jk_ff_bank;

  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] eq;
    logic [3:0] eqn;
    logic [3:0] eill;
    logic [3:0] echg;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_clr;
  logic [1:0] a_mode;
  logic [3:0] a_s, a_r, a_q, a_qn, a_ill, a_chg;
  logic       b_rst, b_en, b_clr;
  logic [1:0] b_mode;
  logic [3:0] b_s, b_r, b_q, b_qn, b_ill, b_chg;

  int total = 0;
  int bad   = 0;

  sr_jk_ff_bank #(.WIDTH(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .s(a_s), .r(a_r),
    .illegal_clr(a_clr), .q(a_q), .qn(a_qn), .illegal(a_ill), .chg(a_chg)
  );

  sr_jk_ff_bank #(.WIDTH(4), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .s(b_s), .r(b_r),
    .illegal_clr(b_clr), .q(b_q), .qn(b_qn), .illegal(b_ill), .chg(b_chg)
  );

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  vec_t vecs[23];

  initial begin
    //            rst   en    clr   mode   s        r        q        qn       ill      chg
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'b1110, 4'b1111, 4'b0001, 4'b1110, 4'b0000, 4'b0001};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'b1111, 4'b1110, 4'b0000, 4'b1111, 4'b0000, 4'b0001};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'b0111, 4'b0111, 4'b1000, 4'b1111, 4'b1000, 4'b1000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'b1111, 4'b1111, 4'b1000, 4'b0111, 4'b1000, 4'b0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'b00, 4'b0111, 4'b0111, 4'b1000, 4'b1111, 4'b1000, 4'b0000};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b00, 4'b1111, 4'b1111, 4'b1000, 4'b0111, 4'b0000, 4'b0000};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'b10, 4'b0101, 4'b0000, 4'b0101, 4'b1010, 4'b0000, 4'b1101};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b01, 4'b1111, 4'b1111, 4'b1010, 4'b0101, 4'b0000, 4'b1111};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0000, 4'b1001};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 4'b0001};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0001};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 4'b0001};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0001};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 2'b11, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 2'b11, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 2'b10, 4'b1001, 4'b0000, 4'b1001, 4'b0110, 4'b0000, 4'b1001};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 2'b10, 4'b0110, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 2'b00, 4'b0111, 4'b0111, 4'b1000, 4'b1111, 4'b1000, 4'b1000};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 2'b01, 4'b0000, 4'b0000, 4'b1000, 4'b0111, 4'b1000, 4'b0000};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 4'b1000, 4'b0111, 4'b0000, 4'b0000};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 2'b00, 4'b1110, 4'b1110, 4'b1000, 4'b0111, 4'b0000, 4'b0000};

    a_rst = 1'b1; a_en = 1'b0; a_clr = 1'b0; a_mode = 2'b00; a_s = 4'b1111; a_r = 4'b1111;
    b_rst = 1'b1; b_en = 1'b0; b_clr = 1'b0; b_mode = 2'b00; b_s = 4'b0000; b_r = 4'b0000;
    @(posedge clk); #1;

    // Table-driven run on the active-low instance.
    for (int i = 0; i < 23; i++) begin
      a_rst = vecs[i].rst; a_en = vecs[i].en; a_clr = vecs[i].clr;
      a_mode = vecs[i].mode; a_s = vecs[i].s; a_r = vecs[i].r;
      @(posedge clk); #1;
      check("a_q",       i, a_q,   vecs[i].eq);
      check("a_qn",      i, a_qn,  vecs[i].eqn);
      check("a_illegal", i, a_ill, vecs[i].eill);
      check("a_chg",     i, a_chg, vecs[i].echg);
    end

    // Active-high instance: set, forbidden, then immediate switch to D mode.
    b_rst = 1'b1;
    @(posedge clk); #1;
    check("b_rst_q",   0, b_q,   4'b0000);
    check("b_rst_qn",  0, b_qn,  4'b1111);
    b_rst = 1'b0; b_en = 1'b1; b_mode = 2'b00; b_s = 4'b0001; b_r = 4'b0000;
    @(posedge clk); #1;
    check("b_set_q",   1, b_q,   4'b0001);
    check("b_set_qn",  1, b_qn,  4'b1110);
    check("b_set_chg", 1, b_chg, 4'b0001);
    b_s = 4'b0010; b_r = 4'b0010;
    @(posedge clk); #1;
    check("b_forb_q",   2, b_q,   4'b0011);
    check("b_forb_qn",  2, b_qn,  4'b1110);
    check("b_forb_ill", 2, b_ill, 4'b0010);
    check("b_forb_chg", 2, b_chg, 4'b0010);
    b_mode = 2'b10; b_s = 4'b0100; b_r = 4'b0000;
    @(posedge clk); #1;
    check("b_d_q",   3, b_q,   4'b0100);
    check("b_d_qn",  3, b_qn,  4'b1011);
    check("b_d_ill", 3, b_ill, 4'b0010);
    check("b_d_chg", 3, b_chg, 4'b0111);
    // Reset clears a q that was 1 without raising chg.
    b_rst = 1'b1;
    @(posedge clk); #1;
    check("b_rst2_q",   4, b_q,   4'b0000);
    check("b_rst2_chg", 4, b_chg, 4'b0000);
    check("b_rst2_ill", 4, b_ill, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
